port_xfer_ctrl: RTL and testbench

//  Per-input-port packet sequencer between an input FIFO and the switch arbiter/crossbar.
//  - Parses the header beat; raises the request and destination mask to the arbiter.
//  - Holds the allocation until the whole packet has moved through the crossbar.
//  - Releases the allocation after the last beat. Drops malformed packets.
//  - One instance per input port (NUM_PORTS instances).

---
 rtl/packet_pkg.sv | 21 ++
 rtl/port_xfer_ctrl.sv | 146 ++++++++++++++
 tb/tb_port_xfer_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_pkg.sv
// packet_pkg: shared switch constants, header layout and port sequencer state encoding.
package packet_pkg;

    localparam int NUM_PORTS  = 4;
    localparam int ADDR_WIDTH = 4;
    localparam int LEN_W      = 8;

    typedef struct packed {
        logic [LEN_W-1:0]      len;
        logic [ADDR_WIDTH-1:0] dst;
    } hdr_t;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        HDR,
        PAY,
        DROP
    } pxc_state_e;

endpackage

// File: rtl/port_xfer_ctrl.sv
// port_xfer_ctrl: per-input-port packet sequencer between input FIFO and arbiter/crossbar.
// Optional grant watchdog enabled by defining PXC_WATCHDOG_EN.
module port_xfer_ctrl #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = packet_pkg::LEN_W,
    parameter int TIMEOUT = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             in_ready,
    output logic                             arb_req,
    output logic [packet_pkg::ADDR_WIDTH-1:0] arb_dst,
    input  logic                             arb_grant,
    output logic                             out_valid,
    output logic [DATA_W-1:0]                out_data,
    output logic                             out_sop,
    output logic                             out_eop,
    input  logic                             out_ready,
    output logic                             pkt_done,
    output logic                             pkt_drop,
    output logic                             timeout
);
    import packet_pkg::*;

    pxc_state_e            state, state_d;
    logic [DATA_W-1:0]     hdr_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d, drop_q, drop_d;
    logic                  expire;
    logic [ADDR_WIDTH-1:0] in_dst;
    logic [LEN_W-1:0]      in_len;

    assign in_dst = in_data[ADDR_WIDTH-1:0];
    assign in_len = in_data[ADDR_WIDTH+LEN_W-1:ADDR_WIDTH];

    // Every output is forced low while rst is held, even before the state register settles.
    assign in_ready  = !rst && (state == IDLE || state == DROP || (state == PAY && out_ready));
    assign arb_req   = !rst && (state == ARB || state == HDR || state == PAY);
    assign arb_dst   = arb_req ? dst_q : '0;
    assign out_valid = !rst && (state == HDR || (state == PAY && in_valid));
    assign out_data  = rst ? '0 : state == HDR ? hdr_q : state == PAY ? in_data : '0;
    assign out_sop   = out_valid && state == HDR;
    assign out_eop   = out_valid && ((state == HDR && cnt_q == '0) || (state == PAY && cnt_q == LEN_W'(1)));
    assign pkt_done  = !rst && done_q;
    assign pkt_drop  = !rst && drop_q;

    always_comb begin
        state_d = state;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        drop_d  = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                cnt_d = in_len;
                if (in_dst != '0)
                    state_d = ARB;
                else if (in_len != '0)
                    state_d = DROP;
                else
                    drop_d = 1'b1;
            end
            ARB: if (arb_grant) begin
                state_d = HDR;
            end else if (expire) begin
                if (cnt_q != '0)
                    state_d = DROP;
                else begin
                    state_d = IDLE;
                    drop_d  = 1'b1;
                end
            end
            HDR: if (out_ready) begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else
                    state_d = PAY;
            end
            PAY: if (in_valid && out_ready) begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LEN_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            DROP: if (in_valid) begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LEN_W'(1)) begin
                    state_d = IDLE;
                    drop_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            hdr_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            drop_q <= drop_d;
            if (state == IDLE && in_valid) begin
                hdr_q <= in_data;
                dst_q <= in_dst;
            end
        end
    end

`ifdef PXC_WATCHDOG_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_q;
    logic              timeout_q;
    // A grant in the expiry cycle wins because ARB checks arb_grant before expire.
    assign expire  = wait_q == WAIT_W'(TIMEOUT);
    assign timeout = !rst && timeout_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= (state == ARB && !arb_grant && !expire) ? wait_q + 1'b1 : '0;
            timeout_q <= state == ARB && !arb_grant && expire;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    property grant_held_p;
        @(posedge clk) disable iff (rst) (state == HDR || state == PAY) |-> arb_grant;
    endproperty
    assert property (grant_held_p);

endmodule

// File: tb/tb_port_xfer_ctrl.sv
// tb_port_xfer_ctrl: randomized packet traffic checked against a queue-based packet model.
`timescale 1ns/1ps
module tb_port_xfer_ctrl;
    import packet_pkg::*;

    localparam int DATA_W = 32;
    localparam int LW     = 8;

    typedef struct {
        logic [DATA_W-1:0]     data;
        logic                  sop;
        logic                  eop;
        logic [ADDR_WIDTH-1:0] dst;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst, in_valid, in_ready, arb_req, arb_grant;
    logic                  out_valid, out_sop, out_eop, out_ready, pkt_done, pkt_drop, timeout;
    logic [DATA_W-1:0]     in_data, out_data;
    logic [ADDR_WIDTH-1:0] arb_dst;

    logic [DATA_W-1:0] src_q[$];
    beat_t             exp_q[$];
    int total = 0, bad = 0;
    int done_n, drop_n, tmo_n, req_n, pay_n, exp_done, exp_drop, exp_tmo;
    int vprob = 100, rmode = 0, rphase = 0, gdelay = 2, gcnt = 0;
    bit no_grant = 0, prev_eop = 0, in_pay = 0;
    logic [ADDR_WIDTH-1:0] pay_dst;

    port_xfer_ctrl #(.DATA_W(DATA_W), .LEN_W(LW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .arb_req(arb_req), .arb_dst(arb_dst), .arb_grant(arb_grant),
        .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_ready(out_ready), .pkt_done(pkt_done), .pkt_drop(pkt_drop), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic reset_counts();
        done_n = 0; drop_n = 0; tmo_n = 0; req_n = 0; pay_n = 0;
        exp_done = 0; exp_drop = 0; exp_tmo = 0;
    endtask

    // Queue one packet at the FIFO; its expected crossbar beats follow directly from the header fields.
    task automatic add_pkt(input logic [ADDR_WIDTH-1:0] dst, input int len, input bit show);
        logic [DATA_W-1:0] h, p;
        h = $urandom;
        h[ADDR_WIDTH +: LW] = LW'(len);
        h[ADDR_WIDTH-1:0] = dst;
        src_q.push_back(h);
        if (show && dst != 0) exp_q.push_back('{h, 1'b1, len == 0, dst});
        for (int i = 0; i < len; i++) begin
            p = $urandom;
            src_q.push_back(p);
            if (show && dst != 0) exp_q.push_back('{p, 1'b0, i == len - 1, dst});
        end
        if (dst == 0) exp_drop++;
        else if (show) exp_done++;
    endtask

    // One clock: drive at the falling edge, sample 1ns later, then wait for the next falling edge.
    task automatic cycle();
        beat_t b;
        bit ohs, ihs;
        arb_grant = arb_req && !no_grant && gcnt >= gdelay;
        gcnt = arb_req ? gcnt + 1 : 0;
        in_valid = src_q.size() > 0 && $urandom_range(99) < vprob;
        in_data = in_valid ? src_q[0] : DATA_W'($urandom);
        out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (rphase % 4 == 0 || rphase % 4 == 3) : 1'($urandom_range(1));
        rphase++;
        #1;
        if (prev_eop) begin
            total++;
            if (arb_req !== 1'b0) begin bad++; $display("FAIL req_after_eop arb_req=%b want 0", arb_req); end
        end
        if (in_pay) begin
            total++;
            if (in_ready !== out_ready || arb_dst !== pay_dst) begin
                bad++;
                $display("FAIL pay_mirror in_ready=%b out_ready=%b arb_dst=%b want %b", in_ready, out_ready, arb_dst, pay_dst);
            end
        end
        ohs = out_valid && out_ready;
        ihs = in_valid && in_ready;
        if (ohs) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL extra_beat data=%h sop=%b eop=%b want no beat", out_data, out_sop, out_eop);
            end else begin
                b = exp_q.pop_front();
                pay_dst = b.dst;
                if ({out_data, out_sop, out_eop, arb_dst, arb_req} !== {b.data, b.sop, b.eop, b.dst, 1'b1}) begin
                    bad++;
                    $display("FAIL beat data=%h sop=%b eop=%b dst=%b req=%b want data=%h sop=%b eop=%b dst=%b req=1",
                             out_data, out_sop, out_eop, arb_dst, arb_req, b.data, b.sop, b.eop, b.dst);
                end
            end
            if (!out_sop) pay_n++;
            in_pay = !out_eop;
        end
        prev_eop = ohs && out_eop;
        if (ihs) void'(src_q.pop_front());
        done_n += int'(pkt_done);
        drop_n += int'(pkt_drop);
        tmo_n += int'(timeout);
        req_n += int'(arb_req);
        @(negedge clk);
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while ((src_q.size() > 0 || exp_q.size() > 0 || arb_req) && n < max) begin
            cycle();
            n++;
        end
        total++;
        if (n >= max) begin
            bad++;
            $display("FAIL idle_bound src_left=%0d beats_left=%0d arb_req=%b want all drained", src_q.size(), exp_q.size(), arb_req);
        end
        repeat (2) cycle();
    endtask

    task automatic check_counts(input string name);
        total++;
        if (done_n !== exp_done) begin bad++; $display("FAIL %s_done got=%0d want=%0d", name, done_n, exp_done); end
        total++;
        if (drop_n !== exp_drop) begin bad++; $display("FAIL %s_drop got=%0d want=%0d", name, drop_n, exp_drop); end
        total++;
        if (tmo_n !== exp_tmo) begin bad++; $display("FAIL %s_timeout got=%0d want=%0d", name, tmo_n, exp_tmo); end
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL %s_missing got=%0d beats left want 0", name, exp_q.size()); end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; arb_grant = 1'b0; out_ready = 1'b0; in_data = '0;
        #1;
        total++;
        if ({in_ready, arb_req, arb_dst, out_valid, out_data, out_sop, out_eop, pkt_done, pkt_drop, timeout} !== '0) begin
            bad++;
            $display("FAIL reset_hold rdy=%b req=%b dst=%b ov=%b od=%h sop=%b eop=%b dn=%b dr=%b to=%b want all 0",
                     in_ready, arb_req, arb_dst, out_valid, out_data, out_sop, out_eop, pkt_done, pkt_drop, timeout);
        end
        @(negedge clk);
        rst = 1'b0;
        src_q.delete(); exp_q.delete();
        in_pay = 0; prev_eop = 0; gcnt = 0;
        #1;
        total++;
        if ({arb_req, arb_dst, out_valid, out_sop, out_eop, pkt_done, pkt_drop, timeout} !== '0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle rdy=%b req=%b dst=%b ov=%b sop=%b eop=%b dn=%b dr=%b to=%b want rdy=1 rest 0",
                     in_ready, arb_req, arb_dst, out_valid, out_sop, out_eop, pkt_done, pkt_drop, timeout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; arb_grant = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        do_reset();
    endtask

    task automatic test_unicast();
        reset_counts(); rmode = 0; vprob = 100; gdelay = 2;
        add_pkt(4'b0010, 3, 1);
        run_idle(200);
        check_counts("unicast");
        total++;
        if (req_n !== 7) begin bad++; $display("FAIL unicast_req_cycles got=%0d want=7", req_n); end
        total++;
        if (pay_n !== 3) begin bad++; $display("FAIL unicast_payload got=%0d want=3", pay_n); end
    endtask

    task automatic test_header_only();
        reset_counts(); rmode = 0; vprob = 100; gdelay = 2;
        add_pkt(4'b1000, 0, 1);
        run_idle(200);
        check_counts("hdr_only");
        total++;
        if (req_n !== 4) begin bad++; $display("FAIL hdr_only_req_cycles got=%0d want=4", req_n); end
    endtask

    task automatic test_backpressure();
        reset_counts(); rmode = 1; rphase = 0; vprob = 100; gdelay = 1;
        add_pkt(4'b0101, 4, 1);
        run_idle(300);
        check_counts("backpressure");
        total++;
        if (pay_n !== 4) begin bad++; $display("FAIL backpressure_payload got=%0d want=4", pay_n); end
    endtask

    task automatic test_drop();
        reset_counts(); rmode = 0; vprob = 100;
        add_pkt(4'b0000, 2, 1);
        add_pkt(4'b0000, 0, 1);
        run_idle(200);
        check_counts("drop");
        total++;
        if (req_n !== 0) begin bad++; $display("FAIL drop_req_cycles got=%0d want=0", req_n); end
    endtask

    task automatic test_back_to_back();
        reset_counts(); rmode = 0; vprob = 100; gdelay = 0;
        add_pkt(4'b0001, 2, 1);
        add_pkt(4'b0110, 0, 1);
        add_pkt(4'b0000, 1, 1);
        add_pkt(4'b1111, 3, 1);
        run_idle(300);
        check_counts("back_to_back");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            reset_counts(); rmode = 2; vprob = 70; gdelay = $urandom_range(3);
            for (int k = 0; k < 20; k++)
                add_pkt($urandom_range(4) == 0 ? 4'b0000 : 4'($urandom_range(15)), $urandom_range(6), 1);
            run_idle(5000);
            check_counts("random");
        end
    endtask

    task automatic test_watchdog();
        reset_counts(); rmode = 0; vprob = 100; no_grant = 1;
        add_pkt(4'b0011, 3, 0);
`ifdef PXC_WATCHDOG_EN
        exp_drop = 1; exp_tmo = 1;
        run_idle(300);
        check_counts("watchdog");
        total++;
        if (req_n !== 9) begin bad++; $display("FAIL watchdog_req_cycles got=%0d want=9", req_n); end
`else
        repeat (101) cycle();
        total++;
        if (req_n !== 100) begin bad++; $display("FAIL no_watchdog_req_cycles got=%0d want=100", req_n); end
        total++;
        if (tmo_n !== 0) begin bad++; $display("FAIL no_watchdog_timeout got=%0d want=0", tmo_n); end
        do_reset();
`endif
        no_grant = 0;
    endtask

    task automatic test_reset_mid_pay();
        int n = 0;
        reset_counts(); rmode = 0; vprob = 100; gdelay = 1;
        add_pkt(4'b0100, 5, 1);
        while (pay_n < 2 && n < 100) begin cycle(); n++; end
        total++;
        if (pay_n !== 2) begin bad++; $display("FAIL mid_pay_reach got=%0d want=2", pay_n); end
        do_reset();
        reset_counts();
        add_pkt(4'b1001, 2, 1);
        run_idle(200);
        check_counts("after_reset");
    endtask

    initial begin
        reset_counts();
        test_reset();
        test_unicast();
        test_header_only();
        test_backpressure();
        test_drop();
        test_back_to_back();
        test_random();
        test_watchdog();
        test_reset_mid_pay();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
